// File: rtl/flash_thermo_encoder.sv
// -----------------------------------------------------------------------------
// flash_thermo_encoder
//
// Sits behind the flash ADC comparator bank. It captures the thermometer
// vector, removes isolated bubbles with a 3-input majority vote, and turns the
// corrected vector into a binary code. The code is offered to the Hamming
// encoder stage through a one-deep output slot.
//
// Pipeline:
//   stage 1 : capture register (s1_vec_q / s1_valid_q), loaded by sample_en
//   stage 2 : combinational correct + popcount, loaded into the output slot
//
// Handshake (code_valid / code_ready):
//   code_valid rises only with a freshly loaded code. While code_valid=1 and
//   code_ready=0, code_out and bubble_err are frozen. A transfer happens on
//   every edge where code_valid=1 and code_ready=1. code_ready has no effect
//   while code_valid=0. A stage-1 result that reaches a slot still holding an
//   untransferred code is dropped, and the sticky overrun flag is set.
//
// Parameters:
//   N_BITS      output code width (2..6); NCMP = 2^N_BITS-1 comparators
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sample_en    capture therm_in on this edge
//   therm_in     comparator outputs, bit 0 = lowest reference
//   code_ready   downstream accepts code_out this cycle
//   overrun_clr  clears overrun (and err_count when present)
//   code_out     encoded sample
//   code_valid   code_out holds a code not yet transferred
//   bubble_err   correction changed this sample (qualified by code_valid)
//   overrun      sticky: a sample was dropped
//   err_count    (only with THERMO_ERR_CNT_EN) saturating count of loaded
//                samples that needed correction
//
// Optional feature macro: THERMO_ERR_CNT_EN adds the err_count output.
// -----------------------------------------------------------------------------
module flash_thermo_encoder #(
  parameter int N_BITS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_en,
  input  logic [(1<<N_BITS)-2:0]       therm_in,
  input  logic                         code_ready,
  input  logic                         overrun_clr,
  output logic [N_BITS-1:0]            code_out,
  output logic                         code_valid,
  output logic                         bubble_err,
  output logic                         overrun
`ifdef THERMO_ERR_CNT_EN
  ,
  output logic [7:0]                   err_count
`endif
);

  localparam int NCMP = (1 << N_BITS) - 1;

  // ---------------------------------------------------------------------------
  // Stage 1: capture
  // ---------------------------------------------------------------------------
  logic [NCMP-1:0] s1_vec_q, s1_vec_d;
  logic            s1_valid_q, s1_valid_d;

  always_comb begin
    s1_vec_d   = s1_vec_q;
    s1_valid_d = sample_en;
    if (sample_en) s1_vec_d = therm_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vec_q   <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_vec_q   <= s1_vec_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: bubble correction and encoding
  // ---------------------------------------------------------------------------
  // t_ext pads the vector with a forced 1 below the lowest comparator and a
  // forced 0 above the highest one, so the end bits vote like interior bits.
  // t_ext[k] corresponds to t[k-1].
  logic [NCMP+1:0] t_ext;
  logic [NCMP-1:0] corr_vec;
  logic [N_BITS-1:0] enc_code;
  logic              enc_berr;

  always_comb begin
    t_ext    = {1'b0, s1_vec_q, 1'b1};
    corr_vec = '0;
    enc_code = '0;
    for (int i = 0; i < NCMP; i++) begin
      corr_vec[i] = (t_ext[i]   & t_ext[i+1]) |
                    (t_ext[i]   & t_ext[i+2]) |
                    (t_ext[i+1] & t_ext[i+2]);
    end
    // Popcount of at most NCMP = 2^N_BITS-1 ones always fits in N_BITS.
    for (int i = 0; i < NCMP; i++) begin
      enc_code = enc_code + N_BITS'(corr_vec[i]);
    end
    enc_berr = (corr_vec != s1_vec_q);
  end

  // ---------------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------------
  logic [N_BITS-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              berr_q, berr_d;
  logic              overrun_q, overrun_d;
  logic              slot_free;
  logic              load;
  logic              drop;

  assign slot_free = !valid_q || code_ready;
  assign load      = s1_valid_q && slot_free;
  assign drop      = s1_valid_q && !slot_free;

  always_comb begin
    code_d    = code_q;
    berr_d    = berr_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (load) begin
      code_d  = enc_code;
      berr_d  = enc_berr;
      valid_d = 1'b1;
    end else if (valid_q && code_ready) begin
      // Transfer with nothing behind it: code_out keeps its last value.
      valid_d = 1'b0;
    end

    // A drop on the same edge as a clear must leave the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      berr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      code_q    <= code_d;
      valid_q   <= valid_d;
      berr_q    <= berr_d;
      overrun_q <= overrun_d;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign bubble_err = berr_q;
  assign overrun    = overrun_q;

`ifdef THERMO_ERR_CNT_EN
  // ---------------------------------------------------------------------------
  // Bubble error counter: counts loaded samples only, saturates at 255.
  // A clear coinciding with a counted load leaves the count at 1.
  // ---------------------------------------------------------------------------
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_inc;

  assign err_inc = load && enc_berr;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (overrun_clr) begin
      err_cnt_d = err_inc ? 8'd1 : 8'd0;
    end else if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_flash_thermo_encoder.sv
// -----------------------------------------------------------------------------
// tb_flash_thermo_encoder
//
// Directed bench for flash_thermo_encoder with N_BITS=3. Inputs are driven
// 1 time unit after each rising edge, and outputs are sampled at the same
// point, after the edge has taken effect. Every expected value is written out
// by hand next to its stimulus. err_count checks are present only when
// THERMO_ERR_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_flash_thermo_encoder;

  localparam int N_BITS = 3;
  localparam int NCMP   = (1 << N_BITS) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              rst_n;
  logic              sample_en;
  logic [NCMP-1:0]   therm_in;
  logic              code_ready;
  logic              overrun_clr;
  logic [N_BITS-1:0] code_out;
  logic              code_valid;
  logic              bubble_err;
  logic              overrun;
`ifdef THERMO_ERR_CNT_EN
  logic [7:0]        err_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  flash_thermo_encoder #(.N_BITS(N_BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .therm_in    (therm_in),
    .code_ready  (code_ready),
    .overrun_clr (overrun_clr),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .bubble_err  (bubble_err),
    .overrun     (overrun)
`ifdef THERMO_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic exp_valid,
                           input logic [N_BITS-1:0] exp_code, input logic exp_berr);
    check({tag, ".valid"}, 32'(code_valid), 32'(exp_valid));
    check({tag, ".code"},  32'(code_out),   32'(exp_code));
    check({tag, ".berr"},  32'(bubble_err), 32'(exp_berr));
  endtask

  // One isolated sample with code_ready held high: result appears two edges
  // after the capture edge is set up, then code_valid drops on the next edge.
  task automatic single_sample(input string tag, input logic [NCMP-1:0] vec,
                               input logic [N_BITS-1:0] exp_code, input logic exp_berr);
    therm_in   = vec;
    sample_en  = 1'b1;
    code_ready = 1'b1;
    step();                       // edge k: capture
    sample_en  = 1'b0;
    check({tag, ".pre_valid"}, 32'(code_valid), 32'd0);
    step();                       // edge k+1: load output slot
    check_out(tag, 1'b1, exp_code, exp_berr);
    step();                       // transfer completes, nothing behind it
    check({tag, ".drain_valid"}, 32'(code_valid), 32'd0);
    check({tag, ".drain_code_hold"}, 32'(code_out), 32'(exp_code));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    sample_en   = 1'b0;
    therm_in    = '0;
    code_ready  = 1'b0;
    overrun_clr = 1'b0;
    step();
    step();

    // Reset state
    check_out("reset", 1'b0, 3'd0, 1'b0);
    check("reset.overrun", 32'(overrun), 32'd0);
`ifdef THERMO_ERR_CNT_EN
    check("reset.err_count", 32'(err_count), 32'd0);
`endif
    rst_n = 1'b1;
    step();
    check("post_reset.valid", 32'(code_valid), 32'd0);

    // Main function and boundaries
    single_sample("clean3",   7'b0000111, 3'd3, 1'b0);
    single_sample("bubble3",  7'b0001011, 3'd3, 1'b1);
`ifdef THERMO_ERR_CNT_EN
    check("bubble3.err_count", 32'(err_count), 32'd1);
`endif
    single_sample("full",     7'b1111111, 3'd7, 1'b0);
    single_sample("empty",    7'b0000000, 3'd0, 1'b0);
    single_sample("top_only", 7'b1000000, 3'd0, 1'b1);
`ifdef THERMO_ERR_CNT_EN
    check("top_only.err_count", 32'(err_count), 32'd2);
`endif

    // Backpressure and overrun
    code_ready = 1'b0;
    therm_in   = 7'b0000001;
    sample_en  = 1'b1;
    step();                       // capture A
    therm_in   = 7'b0011111;
    step();                       // A loaded, capture B
    sample_en  = 1'b0;
    check_out("stall_a", 1'b1, 3'd1, 1'b0);
    check("stall_a.overrun", 32'(overrun), 32'd0);
    step();                       // B dropped
    check_out("stall_drop", 1'b1, 3'd1, 1'b0);
    check("stall_drop.overrun", 32'(overrun), 32'd1);
    step();                       // holds while stalled
    check("stall_hold.code", 32'(code_out), 32'd1);
    check("stall_hold.overrun", 32'(overrun), 32'd1);
    code_ready = 1'b1;
    step();
    check("release.valid", 32'(code_valid), 32'd0);
    check("release.code_hold", 32'(code_out), 32'd1);
    check("release.overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("clear.overrun", 32'(overrun), 32'd0);
`ifdef THERMO_ERR_CNT_EN
    check("clear.err_count", 32'(err_count), 32'd0);
`endif

    // Drop and clear on the same edge: set wins
    code_ready = 1'b0;
    therm_in   = 7'b0000011;
    sample_en  = 1'b1;
    step();                       // capture A
    step();                       // A loaded, capture B
    sample_en   = 1'b0;
    overrun_clr = 1'b1;
    step();                       // B dropped while clearing
    overrun_clr = 1'b0;
    check("set_wins.overrun", 32'(overrun), 32'd1);
    check_out("set_wins", 1'b1, 3'd2, 1'b0);
    code_ready  = 1'b1;
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("set_wins.cleared", 32'(overrun), 32'd0);
    check("set_wins.valid", 32'(code_valid), 32'd0);

    // Back-to-back: codes 1..7 on consecutive cycles
    code_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      therm_in  = 7'((1 << i) - 1);
      sample_en = 1'b1;
      step();
      if (i >= 2) begin
        check($sformatf("b2b[%0d].valid", i - 1), 32'(code_valid), 32'd1);
        check($sformatf("b2b[%0d].code", i - 1), 32'(code_out), 32'(i - 1));
      end
    end
    sample_en = 1'b0;
    step();
    check_out("b2b[7]", 1'b1, 3'd7, 1'b0);
    step();
    check("b2b.end_valid", 32'(code_valid), 32'd0);
    check("b2b.overrun", 32'(overrun), 32'd0);

    // Clear coinciding with a counted load leaves count at 1 (when present)
    therm_in  = 7'b0001011;
    sample_en = 1'b1;
    step();                       // capture
    sample_en   = 1'b0;
    overrun_clr = 1'b1;
    step();                       // load with berr=1 and clear
    overrun_clr = 1'b0;
    check_out("clr_inc", 1'b1, 3'd3, 1'b1);
`ifdef THERMO_ERR_CNT_EN
    check("clr_inc.err_count", 32'(err_count), 32'd1);
`endif
    step();

    // Asynchronous reset with data in flight
    code_ready = 1'b0;
    therm_in   = 7'b0000111;
    sample_en  = 1'b1;
    step();                       // capture A
    therm_in   = 7'b0111111;
    step();                       // A loaded, B in stage 1
    sample_en  = 1'b0;
    check_out("pre_rst", 1'b1, 3'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 3'd0, 1'b0);
    check("async_rst.overrun", 32'(overrun), 32'd0);
    step();
    step();
    rst_n      = 1'b1;
    code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_idle[%0d].valid", i), 32'(code_valid), 32'd0);
    end
    single_sample("post_rst", 7'b0011111, 3'd5, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flash_thermo_encoder.md
Name: flash_thermo_encoder

Overview:
- Downstream of the flash ADC comparator bank. Captures the thermometer vector formed by the 2^N_BITS-1 comparator outputs and applies 3-input majority bubble correction.
- Encodes the corrected vector to an N_BITS binary code and presents it on a valid/ready interface to the Hamming encoder stage.
- Registered two-stage pipeline with a one-deep output slot and overrun detection.

Parameters:
- N_BITS, 3, output code width. NCMP = 2^N_BITS-1 comparator inputs (derived localparam, not overridable). Legal range 2..6.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sample_en  input  1  capture therm_in this cycle
- therm_in  input  NCMP  comparator outputs; bit i = comparator with reference i+1 (bit 0 = lowest reference)
- code_ready  input  1  downstream accepts code this cycle
- overrun_clr  input  1  clears overrun flag
- code_out  output  N_BITS  encoded sample
- code_valid  output  1  code_out valid
- bubble_err  output  1  correction changed this sample; qualified by code_valid
- overrun  output  1  sticky; a sample was dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: code_out=0, code_valid=0, bubble_err=0, overrun=0. Stage-1 register and s1_valid also clear to 0.
- Reset asserted mid-operation discards all in-flight samples. The first post-reset capture requires sample_en after rst_n deasserts.
- Stage 1, capture:
  - On a clk edge with sample_en=1: s1_vec<=therm_in, s1_valid<=1.
  - Otherwise s1_valid<=0.
  - therm_in is sampled only when sample_en=1.
- Stage 2, correct and encode (combinational from s1_vec):
  - Extended vector: t[-1]=1, t[NCMP]=0.
  - Correction: c[i]=maj(t[i-1],t[i],t[i+1]) for i=0..NCMP-1.
  - Encoding: code = popcount(c), width N_BITS. The maximum value NCMP fits, so no overflow.
  - Error flag: berr = (c != s1_vec).
- Output slot:
  - Slot is free when code_valid=0, or when code_valid=1 and code_ready=1.
  - Edge with s1_valid=1 and slot free: code_out<=code, bubble_err<=berr, code_valid<=1.
  - Edge with s1_valid=1 and slot not free: result dropped; overrun<=1; code_out, bubble_err and code_valid hold.
  - Edge with s1_valid=0 and code_valid&code_ready: code_valid<=0; code_out holds its last value.
  - code_out and bubble_err never change while code_valid=1 and code_ready=0.
- Latency: sample_en high in cycle k gives code_valid high in cycle k+2 if the slot is free.
- Throughput: sustained 1 sample/cycle when code_ready=1.
- overrun: stays 1 until overrun_clr=1. If overrun_clr and a new drop occur on the same edge, set wins and overrun stays 1.
- code_ready while code_valid=0 has no effect.

Optional Feature:
- THERMO_ERR_CNT_EN defined:
  - Adds output err_count[7:0], reset 0.
  - Increments on every edge that loads a result with berr=1; saturates at 255.
  - Dropped samples are not counted.
  - overrun_clr also clears err_count. If clear and increment occur on the same edge, the result is 1.
- THERMO_ERR_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (N_BITS=3):
- therm_in=7'b0000111, sample_en pulse at cycle k, code_ready=1 -> cycle k+2: code_valid=1, code_out=3, bubble_err=0.
- therm_in=7'b0001011 (bubble) -> code_out=3, bubble_err=1. With THERMO_ERR_CNT_EN: err_count=1.
- Boundaries: therm_in=7'b1111111 -> code_out=7, bubble_err=0. therm_in=7'b0000000 -> code_out=0, bubble_err=0. Isolated top bit 7'b1000000 -> code_out=0, bubble_err=1.
- code_ready=0; samples 7'b0000001 then 7'b0011111 on consecutive cycles -> code_out stays 1, overrun=1. Then raise code_ready -> code_valid drops next cycle. Then overrun_clr -> overrun=0.
- Back-to-back: 7 consecutive samples 0..7'b1111111 (code values 1..7), code_ready=1 -> codes 1..7 on consecutive cycles, no gaps, overrun=0.
- rst_n low while s1_valid=1 and code_valid=1 -> all outputs 0 immediately (asynchronous); no code_valid after release until a new sample_en.
